// File: rtl/vga_sync_rx.sv
// vga_sync_rx: receive-side VGA timing recovery.
// Samples hsync/vsync/rgb through a 2-flop synchronizer, rebuilds h/v
// counters on p_tick, checks line and frame lengths, and declares lock
// after LOCK_FRAMES consecutive good frames.
// Optional build macro: VGA_RX_STATS_EN adds err_count and frame_count.
module vga_sync_rx #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_OFFSET    = 144,
    parameter int V_OFFSET    = 34,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        p_tick,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic [11:0] rgb_out,
    output logic        locked,
    output logic [9:0]  line_len,
    output logic        frame_start,
    output logic        sync_err
`ifdef VGA_RX_STATS_EN
    ,
    output logic [15:0] err_count,
    output logic [15:0] frame_count
`endif
);

    localparam logic [9:0]  CNT_MAX = 10'd1023;
    localparam logic [9:0]  H_TOT_C = 10'(H_TOTAL);
    localparam logic [10:0] V_TOT_C = 11'(V_TOTAL);
    localparam logic [9:0]  H_LO    = 10'(H_OFFSET);
    localparam logic [10:0] H_HI    = 11'(H_OFFSET + H_ACTIVE);
    localparam logic [9:0]  V_LO    = 10'(V_OFFSET);
    localparam logic [10:0] V_HI    = 11'(V_OFFSET + V_ACTIVE);
    localparam logic [2:0]  LF_C    = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    // 10-bit increment that sticks at the all-ones value
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

    logic        hs_p0, hs_p1, vs_p0, vs_p1;
    logic [11:0] rgb_p0, rgb_p1;
    logic        hs_prev, vs_prev, vs_pend, frame_bad;
    logic [9:0]  h_cnt, v_cnt;
    logic [2:0]  good;
    state_t      state;

    logic        hs_edge, vs_edge, frame_edge, line_bad, frame_bad_eval;
    logic        wdog, go_lock, drop_lock, lock_nxt, in_win;
    logic [9:0]  len_nxt, h_nxt, v_nxt;

    // Sync flops for the control inputs; cleared so no spurious edge history survives reset
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            hs_p0 <= 1'b0;
            hs_p1 <= 1'b0;
            vs_p0 <= 1'b0;
            vs_p1 <= 1'b0;
        end else begin
            hs_p0 <= hsync_in;
            hs_p1 <= hs_p0;
            vs_p0 <= vsync_in;
            vs_p1 <= vs_p0;
        end
    end

    // Pixel data takes the same two-flop path so it lines up with the recovered counters
    always_ff @(posedge clk_50) begin
        rgb_p0 <= rgb_in;
        rgb_p1 <= rgb_p0;
    end

    // Next-count and timing-check decode for the current p_tick sample
    always_comb begin
        hs_edge        = hs_p1 & ~hs_prev;
        vs_edge        = vs_p1 & ~vs_prev;
        frame_edge     = hs_edge & (vs_pend | vs_edge);
        len_nxt        = sat_inc(h_cnt);
        h_nxt          = hs_edge ? 10'd0 : len_nxt;
        v_nxt          = frame_edge ? 10'd0 : (hs_edge ? sat_inc(v_cnt) : v_cnt);
        line_bad       = hs_edge & (len_nxt != H_TOT_C);
        frame_bad_eval = frame_bad | line_bad | (({1'b0, v_cnt} + 11'd1) != V_TOT_C);
        wdog           = (h_nxt == CNT_MAX);
        go_lock        = (state == ACQUIRE) & ~wdog & frame_edge & ~frame_bad_eval &
                         ((good + 3'd1) == LF_C);
        drop_lock      = (state == LOCKED) &
                         (wdog | line_bad | (frame_edge & frame_bad_eval));
        lock_nxt       = go_lock | ((state == LOCKED) & ~drop_lock);
        in_win         = (h_nxt >= H_LO) && ({1'b0, h_nxt} < H_HI) &&
                         (v_nxt >= V_LO) && ({1'b0, v_nxt} < V_HI);
    end

    // Horizontal/vertical counters, line length capture and frame-boundary tracking
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            vs_pend     <= 1'b0;
            frame_bad   <= 1'b0;
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            line_len    <= 10'd0;
            frame_start <= 1'b0;
        end else if (p_tick) begin
            hs_prev     <= hs_p1;
            vs_prev     <= vs_p1;
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            frame_start <= frame_edge;
            if (hs_edge)
                line_len <= len_nxt;
            if (frame_edge)
                vs_pend <= 1'b0;
            else if (vs_edge)
                vs_pend <= 1'b1;
            if (frame_edge)
                frame_bad <= 1'b0;
            else if (line_bad)
                frame_bad <= 1'b1;
        end
    end

    // Lock FSM: SEARCH waits for a frame boundary, ACQUIRE counts good frames, LOCKED watches for any fault
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SEARCH;
            good     <= 3'd0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else if (p_tick) begin
            locked   <= lock_nxt;
            sync_err <= drop_lock;
            case (state)
                SEARCH: begin
                    good <= 3'd0;
                    if (frame_edge)
                        state <= ACQUIRE;
                end
                ACQUIRE: begin
                    if (wdog) begin
                        state <= SEARCH;
                        good  <= 3'd0;
                    end else if (frame_edge) begin
                        if (frame_bad_eval) begin
                            good <= 3'd0;
                        end else begin
                            good <= good + 3'd1;
                            if (go_lock)
                                state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (drop_lock) begin
                        state <= SEARCH;
                        good  <= 3'd0;
                    end
                end
                default: begin
                    state <= SEARCH;
                    good  <= 3'd0;
                end
            endcase
        end
    end

    // Coordinates and gated pixel output, all taken from the same next-count view
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            x        <= 10'd0;
            y        <= 10'd0;
            video_on <= 1'b0;
            rgb_out  <= 12'd0;
        end else if (p_tick) begin
            if (in_win) begin
                x <= h_nxt - H_LO;
                y <= v_nxt - V_LO;
            end
            video_on <= in_win & lock_nxt;
            rgb_out  <= (in_win & lock_nxt) ? rgb_p1 : 12'd0;
        end
    end

`ifdef VGA_RX_STATS_EN
    // Error counter saturates; frame counter wraps and counts only frames seen while locked
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            err_count   <= 16'd0;
            frame_count <= 16'd0;
        end else if (p_tick) begin
            if (drop_lock && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
            if (frame_edge && locked)
                frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: scoreboard bench for vga_sync_rx using a reduced raster
// (40 x 20 ticks, 24 x 12 active window at offset 12/5) so many frames fit
// in a short run. Stimulus pushes expected events; a monitor pops them.
module tb_vga_sync_rx;

    logic        clk_50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        p_tick = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [11:0] rgb_in = 12'd0;
    logic [9:0]  x, y, line_len;
    logic        video_on, locked, frame_start, sync_err;
    logic [11:0] rgb_out;
`ifdef VGA_RX_STATS_EN
    logic [15:0] err_count, frame_count;
`endif

    vga_sync_rx #(
        .H_TOTAL(40), .V_TOTAL(20), .H_ACTIVE(24), .V_ACTIVE(12),
        .H_OFFSET(12), .V_OFFSET(5), .LOCK_FRAMES(2)
    ) dut (
        .clk_50(clk_50), .reset_n(reset_n), .p_tick(p_tick),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .x(x), .y(y), .video_on(video_on), .rgb_out(rgb_out),
        .locked(locked), .line_len(line_len),
        .frame_start(frame_start), .sync_err(sync_err)
`ifdef VGA_RX_STATS_EN
        , .err_count(err_count), .frame_count(frame_count)
`endif
    );

    always #10 clk_50 = ~clk_50;

    typedef struct {
        int idx; bit pix; bit fs; bit se; bit lk; int ll; int xx; int yy; int rgb;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  passes = 0;
    int  pix_sent = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive_pix(input bit hs, input bit vs, input logic [11:0] rgb);
        @(negedge clk_50);
        p_tick = 1'b1; hsync_in = hs; vsync_in = vs; rgb_in = rgb;
        pix_sent++;
        @(negedge clk_50);
        p_tick = 1'b0;
    endtask

    task automatic push_pulse(input int idx, input bit fs, input bit se, input bit lk, input int ll);
        ev_t e;
        e.idx = idx; e.pix = 1'b0; e.fs = fs; e.se = se; e.lk = lk; e.ll = ll;
        e.xx = 0; e.yy = 0; e.rgb = 0;
        q.push_back(e);
    endtask

    task automatic push_pix(input int xx, input int yy, input int rgb);
        ev_t e;
        e.idx = pix_sent; e.pix = 1'b1; e.fs = 1'b0; e.se = 1'b0; e.lk = 1'b1; e.ll = 40;
        e.xx = xx; e.yy = yy; e.rgb = rgb;
        q.push_back(e);
    endtask

    // Marker pixels: three inside the window (corners and an interior point), four just outside
    function automatic logic [11:0] pix_rgb(input int l, input int p);
        if (l == 5  && p == 12) return 12'h0F0;
        if (l == 8  && p == 22) return 12'hF00;
        if (l == 16 && p == 35) return 12'h00F;
        if ((l == 8 && (p == 11 || p == 36)) || (p == 20 && (l == 4 || l == 17)))
            return 12'hFFF;
        return 12'h000;
    endfunction

    task automatic send_frame(input int nlines, input int short_l, input bit fs_se,
                              input bit fs_lk, input int fs_ll, input bit vis, input bit vs_tail);
        int len;
        logic [11:0] c;
        bit v;
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_l) ? 39 : 40;
            for (int p = 0; p < len; p++) begin
                if (l == 0 && p == 0) push_pulse(pix_sent, 1'b1, fs_se, fs_lk, fs_ll);
                if (short_l >= 0 && l == short_l + 1 && p == 0)
                    push_pulse(pix_sent, 1'b0, 1'b1, 1'b0, 39);
                c = pix_rgb(l, p);
                if (vis && c != 12'h000 && c != 12'hFFF) push_pix(p - 12, l - 5, int'(c));
                v = (l < 2) || (vs_tail && l == nlines - 1 && p >= 20);
                drive_pix(p < 4, v, c);
            end
        end
    endtask

    // Monitor: every frame_start, sync_err or non-zero pixel must match the next expected event
    always @(posedge clk_50) begin
        if (p_tick) begin
            #1;
            if (frame_start || sync_err || rgb_out != 12'd0) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_event: idx=%0d fs=%0d se=%0d lk=%0d rgb=%h x=%0d y=%0d, none required",
                             pix_sent - 2, frame_start, sync_err, locked, rgb_out, x, y);
                end else begin
                    ev_t e;
                    bit ok;
                    e = q.pop_front();
                    ok = (pix_sent - 2 == e.idx) && (frame_start == e.fs) && (sync_err == e.se) &&
                         (locked == e.lk) && (e.ll < 0 || int'(line_len) == e.ll) &&
                         (e.pix ? (int'(x) == e.xx && int'(y) == e.yy && int'(rgb_out) == e.rgb && video_on)
                                : (rgb_out == 12'd0));
                    if (ok) passes++;
                    else $display("FAIL event: got idx=%0d fs=%0d se=%0d lk=%0d ll=%0d x=%0d y=%0d rgb=%h von=%0d; required idx=%0d fs=%0d se=%0d lk=%0d ll=%0d x=%0d y=%0d rgb=%h",
                                  pix_sent - 2, frame_start, sync_err, locked, line_len, x, y, rgb_out, video_on,
                                  e.idx, e.fs, e.se, e.lk, e.ll, e.xx, e.yy, e.rgb);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_x"}, int'(x), 0);
        chk({tag, "_y"}, int'(y), 0);
        chk({tag, "_video_on"}, int'(video_on), 0);
        chk({tag, "_rgb_out"}, int'(rgb_out), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_line_len"}, int'(line_len), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_sync_err"}, int'(sync_err), 0);
`ifdef VGA_RX_STATS_EN
        chk({tag, "_err_count"}, int'(err_count), 0);
`endif
    endtask

    initial begin
        int e;
        repeat (3) drive_pix(1'b0, 1'b0, 12'h000);
        check_all_zero("reset");
        #5 reset_n = 1'b1;
        repeat (20) drive_pix(1'b0, 1'b0, 12'h000);

        // Acquire: lock on the third frame_start
        send_frame(20, -1, 0, 0, -1, 0, 0);
        send_frame(20, -1, 0, 0, 40, 0, 0);
        send_frame(20, -1, 0, 1, 40, 1, 0);
        // Short line while locked, then relock
        send_frame(20, 2, 0, 1, 40, 0, 0);
        send_frame(20, -1, 0, 0, 40, 0, 0);
        send_frame(20, -1, 0, 0, 40, 0, 0);
        send_frame(20, -1, 0, 1, 40, 1, 0);
        // Short frame: lock lost only at the next frame_start
        send_frame(19, -1, 0, 1, 40, 1, 0);
        send_frame(20, -1, 1, 0, 40, 0, 0);
        // Vsync edge mid-line: frame starts on the following hsync edge
        send_frame(20, -1, 0, 0, 40, 0, 1);
        send_frame(20, -1, 0, 0, 40, 0, 0);
        send_frame(20, -1, 0, 1, 40, 1, 0);
        // Watchdog: hsync stops while locked
        send_frame(10, -1, 0, 1, 40, 1, 0);
        e = pix_sent;
        push_pulse(e + 1023, 1'b0, 1'b1, 1'b0, 40);
        for (int i = 0; i < 1100; i++) drive_pix(i < 4, 1'b0, (i >= 1040) ? 12'hFFF : 12'h000);
        chk("stall_locked", int'(locked), 0);
        chk("stall_video_on", int'(video_on), 0);
        chk("stall_rgb_out", int'(rgb_out), 0);
        send_frame(20, -1, 0, 0, 1023, 0, 0);
        send_frame(20, -1, 0, 0, 40, 0, 0);
        // Reset mid active line while locked
        send_frame(9, -1, 0, 1, 40, 1, 0);
        for (int p = 0; p < 20; p++) drive_pix(p < 4, 1'b0, 12'h000);
        chk("pre_reset_video_on", int'(video_on), 1);
        chk("pre_reset_locked", int'(locked), 1);
`ifdef VGA_RX_STATS_EN
        chk("pre_reset_err_count", int'(err_count), 3);
`endif
        #3 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        repeat (3) drive_pix(1'b0, 1'b0, 12'h000);
        #5 reset_n = 1'b1;
        send_frame(20, -1, 0, 0, -1, 0, 0);
        send_frame(20, -1, 0, 0, 40, 0, 0);
        send_frame(20, -1, 0, 1, 40, 1, 0);
        repeat (4) drive_pix(1'b0, 1'b0, 12'h000);
        repeat (4) @(negedge clk_50);
        chk("leftover_events", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

Receive-side counterpart of the VGA transmit path. It samples an incoming hsync/vsync/rgb stream of the same format our 640x480 generator drives, recovers pixel coordinates, validates line and frame timing, and declares lock. It sits between the VGA input pins (or a loopback of our own transmitter) and downstream screen-content / screen-off logic, which must trust `x`, `y` and `rgb_out` only while `locked` is high.

## Interface
Parameters:
- `H_TOTAL`, 800, p_ticks per line
- `V_TOTAL`, 525, lines per frame
- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `H_OFFSET`, 144, `h_cnt` value of first active pixel (sync + back porch)
- `V_OFFSET`, 34, `v_cnt` value of first active line
- `LOCK_FRAMES`, 2, consecutive good frames required for lock (1..7)

Ports (clock and reset first):
- `clk_50` in 1 — system clock
- `reset_n` in 1 — asynchronous, active-low reset
- `p_tick` in 1 — one-cycle pixel enable (25 MHz rate)
- `hsync_in` in 1 — horizontal sync, active-high pulse
- `vsync_in` in 1 — vertical sync, active-high pulse
- `rgb_in` in 12 — pixel data
- `x` out 10 — recovered column, 0..639
- `y` out 10 — recovered row, 0..479
- `video_on` out 1 — inside active window and `locked`
- `rgb_out` out 12 — aligned pixel data, zero when `video_on`=0
- `locked` out 1 — timing validated
- `line_len` out 10 — length of last completed line, in p_ticks
- `frame_start` out 1 — one-p_tick pulse at frame boundary
- `sync_err` out 1 — one-p_tick pulse when lock is lost

## Operation
- Input stage: `hsync_in`, `vsync_in`, `rgb_in` pass through a 2-flop `clk_50` synchronizer. All subsequent logic advances only on `p_tick`.
- Edge detection: leading edge = synchronized sample 1 while the previous p_tick sample was 0.
- `h_cnt` (10 bit):
  - cleared to 0 on an hsync leading edge; otherwise increments, saturating at 1023.
  - On that edge, `line_len` <= old `h_cnt`+1 (saturates at 1023).
- vsync leading edge sets `vs_pend`. The next hsync edge clears `vs_pend`, sets `v_cnt`=0 and pulses `frame_start`. Other hsync edges increment `v_cnt`, saturating at 1023.
- If vsync and hsync leading edges occur on the same p_tick, that edge is the frame start.
- Window:
  - `h_cnt` in [H_OFFSET, H_OFFSET+H_ACTIVE) and `v_cnt` in [V_OFFSET, V_OFFSET+V_ACTIVE).
  - `x` = `h_cnt`−H_OFFSET and `y` = `v_cnt`−V_OFFSET inside the window; both hold last value outside.
- `frame_bad` flag:
  - cleared at frame start;
  - set by any completed `line_len` ≠ H_TOTAL;
  - set at frame start if the outgoing `v_cnt`+1 ≠ V_TOTAL.
- FSM:
  - **SEARCH**: first frame start -> ACQUIRE with `good`=0.
  - **ACQUIRE**: each frame start evaluates the frame just ended. Good: `good`+1, and when it reaches LOCK_FRAMES -> LOCKED. Bad: `good`=0, stay in ACQUIRE.
  - **LOCKED**: any bad line or bad frame -> SEARCH with a `sync_err` pulse.
- Watchdog: `h_cnt` reaching 1023 in any state -> SEARCH and `good`=0. Pulses `sync_err` if the FSM was LOCKED.
- The first partial line and first partial frame after reset or SEARCH are never evaluated.

## Timing
- Reset values: `x`=0, `y`=0, `video_on`=0, `rgb_out`=0, `locked`=0, `line_len`=0, `frame_start`=0, `sync_err`=0, FSM=SEARCH, all counters 0.
- All outputs are registered and update only on `p_tick`.
- Latency: an input edge is visible 2 `clk_50` cycles later, on the next `p_tick` sample. `rgb_out` follows the same path, so it stays pixel-aligned with `x`/`y`.
- `locked` rises on the same p_tick as the qualifying `frame_start` and falls on the same p_tick as `sync_err`.
- `reset_n` low mid-frame clears everything immediately. Lock is reacquired only after a full SEARCH/ACQUIRE cycle.

## Configuration
- `VGA_RX_STATS_EN` defined:
  - adds output `err_count` [15:0], incremented on each `sync_err` and saturating at 65535;
  - adds output `frame_count` [15:0], incremented on each `frame_start` while `locked`, wrapping;
  - both reset to 0.
- Undefined: neither port nor its logic exists.

## Test plan
- Loopback from our 640x480 generator after reset -> `locked`=1 at the 3rd `frame_start`; `line_len`=800. Pixel with `rgb_in`=12'hF00 at column 100, row 50 appears with `x`=100, `y`=50, `rgb_out`=12'hF00.
- While locked, one line shortened to 799 p_ticks -> `sync_err` pulse at that line's end; `locked`=0; relock after 3 frame starts.
- Frame with 524 lines -> no lock loss mid-frame; `sync_err` and unlock at the next `frame_start`.
- hsync held low while locked -> after 1023 p_ticks without an edge, `sync_err` pulse; FSM in SEARCH; `video_on`=0, `rgb_out`=0.
- vsync and hsync edges on the same p_tick -> `frame_start` on that p_tick; the following line has `v_cnt`=1.
- `reset_n` pulsed low mid-active-line while locked -> all outputs 0 immediately; lock restored after 3 frame starts. With `VGA_RX_STATS_EN`, `err_count`=0 after reset.
